// File: rtl/spi_slave_ctrl_if.sv
// Serial-side and memory-side signal bundle for spi_slave_ctrl.
// The master modport is the environment (SPI master plus memory); the slave modport is the controller.
interface spi_slave_ctrl_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame controller: 10-bit command/address/data frames in, 8-bit read data out on MISO.
// Optional macro SPI_RD_ORDER_CHECK_EN discards read frames whose command bits are out of order.
module spi_slave_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [8:0] r_rx_shift;
    logic [9:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_miso;
    logic       r_rd_flag;
    logic [7:0] r_tx_shift;
    logic       r_rx_done;
    logic       r_tx_armed;
    logic       r_tx_loaded;

    logic [9:0] w_word;
    logic       w_order_ok;

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

    // w_word is the complete frame as it stands on the edge that samples bit 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_word     = {r_rx_shift, bus.MOSI};
        w_order_ok = 1'b1;
`ifdef SPI_RD_ORDER_CHECK_EN
        case (r_state)
            READ_ADD:  w_order_ok = (w_word[9:8] == 2'b10);
            READ_DATA: w_order_ok = (w_word[9:8] == 2'b11);
            default:   w_order_ok = 1'b1;
        endcase
`else
        w_order_ok = 1'b1;
`endif
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 4'd0;
            r_rx_shift  <= 9'd0;
            r_rx_data   <= 10'h000;
            r_rx_valid  <= 1'b0;
            r_miso      <= 1'b0;
            r_rd_flag   <= 1'b0;
            r_tx_shift  <= 8'd0;
            r_rx_done   <= 1'b0;
            r_tx_armed  <= 1'b0;
            r_tx_loaded <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;

            if (bus.SS_n) begin
                // Deselect aborts whatever is in flight, including a frame on its bit-0 edge.
                r_state     <= IDLE;
                r_bit_cnt   <= 4'd0;
                r_rx_done   <= 1'b0;
                r_tx_armed  <= 1'b0;
                r_tx_loaded <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= CHK_CMD;
                    end

                    CHK_CMD: begin
                        r_rx_shift  <= {8'd0, bus.MOSI};
                        r_bit_cnt   <= 4'd0;
                        r_rx_done   <= 1'b0;
                        r_tx_armed  <= 1'b0;
                        r_tx_loaded <= 1'b0;
                        if (!bus.MOSI)
                            r_state <= WRITE;
                        else if (!r_rd_flag)
                            r_state <= READ_ADD;
                        else
                            r_state <= READ_DATA;
                    end

                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_rx_done) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_rx_done <= 1'b1;
                                if (w_order_ok) begin
                                    r_rx_data  <= w_word;
                                    r_rx_valid <= 1'b1;
                                end
                                if (r_state == READ_ADD && w_order_ok)
                                    r_rd_flag <= 1'b1;
                                else if (r_state == READ_DATA)
                                    r_rd_flag <= 1'b0;
                                r_tx_armed <= (r_state == READ_DATA) && w_order_ok;
                            end else begin
                                r_rx_shift <= {r_rx_shift[7:0], bus.MOSI};
                                r_bit_cnt  <= r_bit_cnt + 4'd1;
                            end
                        end else if (r_state == READ_DATA && r_tx_armed) begin
                            // Only the first tx_valid after the frame loads; later ones are ignored.
                            if (!r_tx_loaded) begin
                                if (bus.tx_valid) begin
                                    r_tx_shift  <= bus.tx_data;
                                    r_tx_loaded <= 1'b1;
                                    r_bit_cnt   <= 4'd0;
                                end
                            end else if (r_bit_cnt != 4'd8) begin
                                r_miso     <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 The block SHALL have the ports below; clk is the SPI serial clock, and all logic is clocked on posedge clk.
REQ-002 clk  input  1  serial clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low, frames a transaction.
REQ-005 MOSI  input  1  serial data in, MSB first.
REQ-006 MISO  output  1  serial read data out, MSB first.
REQ-007 rx_data  output  10  received word; bits [9:8] are the command, bits [7:0] are addr/data.
REQ-008 rx_valid  output  1  one-cycle strobe indicating rx_data is valid.
REQ-009 tx_data  input  8  read data returned by the memory.
REQ-010 tx_valid  input  1  tx_data valid strobe.

Function
REQ-011 The FSM SHALL have exactly five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE SHALL go to CHK_CMD when SS_n=0, and SHALL otherwise stay in IDLE.
REQ-013 CHK_CMD SHALL sample MOSI as bit 9; on 0 it goes to WRITE, on 1 it goes to READ_ADD if rd_flag=0, else to READ_DATA.
REQ-014 WRITE, READ_ADD and READ_DATA SHALL shift in MOSI as bits 8..0 on 9 consecutive edges, using a 4-bit bit counter.
REQ-015 On the edge that samples bit 0, the block SHALL update rx_data and set rx_valid=1 for exactly one cycle.
REQ-016 rd_flag SHALL be set when a READ_ADD frame completes and cleared when a READ_DATA frame completes; a WRITE frame SHALL leave it unchanged.
REQ-017 WRITE and READ_ADD SHALL hold their state, with rx_valid=0 and MISO=0, after bit 0 until SS_n=1.
REQ-018 READ_DATA, after rx_valid, SHALL wait for tx_valid=1 and load tx_data into an 8-bit shift register on that edge.
REQ-019 On the 8 edges after the load, MISO SHALL present tx_data[7] down to tx_data[0], one bit per edge; after that, MISO SHALL be 0.
REQ-020 MOSI SHALL be ignored during the wait and MISO phases of READ_DATA.
REQ-021 tx_valid outside READ_DATA, or a second tx_valid within the same frame, SHALL be ignored.
REQ-022 SS_n=1 in any state SHALL move the FSM to IDLE on the next edge, abort the frame, clear the counter and MISO, suppress rx_valid, and leave rd_flag unchanged.
REQ-023 If SS_n=1 and bit 0 are sampled on the same edge, the abort SHALL take priority: no rx_valid is issued and rd_flag is unchanged.
REQ-024 SS_n=0 held in IDLE after an abort SHALL start a new frame, entering CHK_CMD on the next edge.
REQ-025 rx_data SHALL hold its last value between frames.

Reset
REQ-026 When rst_n=0 on an edge, the block SHALL set state=IDLE, rx_data=10'h000, rx_valid=0, MISO=0, rd_flag=0, the bit counter to 0 and the shift register to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid, and SS_n SHALL be ignored while rst_n=0.

Configuration
REQ-028 Macro SPI_RD_ORDER_CHECK_EN SHALL control the read-order check described below.
REQ-029 With SPI_RD_ORDER_CHECK_EN defined, a READ_DATA frame whose received bits [9:8] are not 2'b11 SHALL be discarded: no rx_valid, no tx load, MISO=0, rd_flag cleared.
REQ-030 With SPI_RD_ORDER_CHECK_EN defined, a READ_ADD frame whose bits [9:8] are not 2'b10 SHALL be discarded: no rx_valid, rd_flag unchanged.
REQ-031 Without SPI_RD_ORDER_CHECK_EN, every completed frame SHALL be forwarded with rx_valid regardless of bits [9:8].

Verification
REQ-032 Reset, then SS_n=0 and MOSI 10'b00_1010_0101 -> rx_valid=1 for one cycle with rx_data=10'h0A5; FSM passes CHK_CMD->WRITE.
REQ-033 Read-address frame 10'h2_3C -> rx_valid with rx_data=10'h23C and rd_flag=1; then a read-data frame 10'h3_00 with tx_valid and tx_data=8'hC6 one cycle after rx_valid -> MISO serialises 1,1,0,0,0,1,1,0 and rd_flag=0.
REQ-034 SS_n=1 after 6 bits of a write frame -> no rx_valid, FSM in IDLE next edge; the following full frame 10'h155 -> rx_data=10'h155.
REQ-035 rst_n=0 during the MISO phase of a read -> MISO=0, rd_flag=0, and the next 1xx frame enters READ_ADD.
REQ-036 With SPI_RD_ORDER_CHECK_EN defined, rd_flag=1 and a READ_DATA frame 10'h2_FF -> no rx_valid, MISO stays 0, rd_flag=0; without the macro, rx_valid=1 with rx_data=10'h2FF.
